// File: rtl/word_data_mem.sv
// Data-word memory responder for the PLC word core: wait-stated core port plus a
// low-priority host port that shares a single-port word array.
module word_data_mem #(
    parameter int unsigned DA_W    = 16,
    parameter int unsigned DW_W    = 32,
    parameter int unsigned MEM_AW  = 10,
    parameter int unsigned RD_WAIT = 1,
    parameter int unsigned WR_WAIT = 0
) (
    input  logic              CLK,
    input  logic              CLR,
    input  logic [DA_W-1:0]   DW_A,
    input  logic [DW_W-1:0]   DW_D,
    output logic [DW_W-1:0]   DW_Q,
    input  logic              DW_OE,
    input  logic              DW_WE,
    output logic              DW_RDY,
    input  logic              HOST_REQ,
    input  logic              HOST_WE,
    input  logic [MEM_AW-1:0] HOST_A,
    input  logic [DW_W-1:0]   HOST_D,
    output logic [DW_W-1:0]   HOST_Q,
    output logic              HOST_ACK
);

    localparam int unsigned CNT_W = 4;
    localparam int unsigned DEPTH = 1 << MEM_AW;

    logic [DW_W-1:0]   r_mem [DEPTH];
    logic [CNT_W-1:0]  r_cnt;
    logic [DW_W-1:0]   r_dw_q;
    logic [DW_W-1:0]   r_host_q;
    logic              r_host_ack;

    logic              w_creq;
    logic [CNT_W-1:0]  w_wait;
    logic              w_rdy;
    logic              w_done;
    logic              w_core_wr;
    logic              w_core_rd;
    logic              w_host_go;
    logic              w_host_wr;
    logic              w_host_rd;
    logic              w_mem_we;
    logic [MEM_AW-1:0] w_addr;
    logic [DW_W-1:0]   w_wdata;
    logic [DW_W-1:0]   w_rdata;
    logic              w_unused_addr;

    // Upper core address bits alias onto the array.
    assign w_unused_addr = ^DW_A[DA_W-1:MEM_AW];

    // Core handshake: write wins over read when both strobes are set.
    assign w_creq    = DW_OE | DW_WE;
    assign w_wait    = DW_WE ? CNT_W'(WR_WAIT) : CNT_W'(RD_WAIT);
    assign w_rdy     = ~w_creq | (r_cnt == w_wait);
    assign w_done    = w_creq & w_rdy & ~CLR;
    assign w_core_wr = w_done & DW_WE;
    assign w_core_rd = w_done & ~DW_WE;

    // Host only sees the array when the core is idle; ACK masks a repeat grant.
    assign w_host_go = HOST_REQ & ~w_creq & ~r_host_ack & ~CLR;
    assign w_host_wr = w_host_go & HOST_WE;
    assign w_host_rd = w_host_go & ~HOST_WE;

    // Single shared port: the core owns it whenever it is requesting.
    assign w_addr   = w_creq ? DW_A[MEM_AW-1:0] : HOST_A;
    assign w_wdata  = w_creq ? DW_D : HOST_D;
    assign w_mem_we = w_core_wr | w_host_wr;
    assign w_rdata  = r_mem[w_addr];

    // Array contents survive reset.
    always_ff @(posedge CLK) begin
        if (w_mem_we) begin
            r_mem[w_addr] <= w_wdata;
        end
    end

    always_ff @(posedge CLK) begin
        if (CLR) begin
            r_cnt <= '0;
        end else if (!w_creq || w_rdy) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (CLR) begin
            r_dw_q <= '0;
        end else if (w_core_rd) begin
            r_dw_q <= w_rdata;
        end
    end

    always_ff @(posedge CLK) begin
        if (CLR) begin
            r_host_q   <= '0;
            r_host_ack <= 1'b0;
        end else begin
            r_host_ack <= w_host_go;
            if (w_host_rd) begin
                r_host_q <= w_rdata;
            end
        end
    end

    assign DW_RDY   = w_rdy;
    assign DW_Q     = r_dw_q;
    assign HOST_Q   = r_host_q;
    assign HOST_ACK = r_host_ack;

endmodule
